check_collision: RTL and testbench
==================================

CHECK_COLLISION -- requirements
Module: check_collision

Interface
REQ-001 SHALL have parameter SPRITE_W, 16, sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, 16, sprite height in pixels.
REQ-003 SHALL have parameters ARENA_XMIN 16, ARENA_XMAX 608, ARENA_YMIN 16, ARENA_YMAX 448, inclusive legal range of the sprite top-left corner.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PacX  input  10  sprite top-left X, unsigned pixels.
REQ-007 SHALL have port PacY  input  9  sprite top-left Y, unsigned pixels.
REQ-008 SHALL have port state  input  2  intended move direction: 00 up (Y-1), 01 down (Y+1), 10 left (X-1), 11 right (X+1).
REQ-009 SHALL have port result  output  1  1 = one-pixel move in state is free, 0 = blocked.

Function
REQ-010 SHALL form the candidate position by applying state to (PacX, PacY), offset exactly 1 pixel on one axis.
REQ-011 SHALL compute the candidate in at least 11-bit signed width; PacX=0 left or PacY=0 up yields a negative candidate, never a wrapped one.
REQ-012 SHALL flag blocked when candidate X < ARENA_XMIN or > ARENA_XMAX, or candidate Y < ARENA_YMIN or > ARENA_YMAX.
REQ-013 SHALL flag blocked when box [cx, cx+SPRITE_W-1] x [cy, cy+SPRITE_H-1] overlaps any wall rectangle (inclusive bounds) on both axes.
REQ-014 SHALL use walls (x0-x1, y0-y1): W0 280-359,200-279; W1 64-127,64-95; W2 512-575,64-95; W3 64-127,384-415; W4 512-575,384-415; W5 160-175,200-279; W6 464-479,200-279; W7 280-359,64-79.
REQ-015 SHALL register result: inputs sampled at edge N drive result after edge N; one-cycle latency; evaluation every cycle, no handshake.
REQ-016 SHALL ignore the current position's own overlap; only the candidate box is tested.

Reset
REQ-017 SHALL drive result to 0 (blocked) on any clock edge with rst=1, including mid-operation.
REQ-018 SHALL resume evaluation on the first edge after rst deasserts, result valid one cycle later.

Configuration
REQ-019 SHALL check walls W0-W7 only when macro CHECK_COLLISION_INNER_WALLS_EN is defined; without it only the arena bounds of REQ-012 apply.

Structure
REQ-020 SHALL place the direction encoding typedef, sprite/arena constants, and wall rectangle table in shared package collision_pkg.
REQ-021 SHALL implement the per-rectangle overlap test as sub-module wall_hit, one instance per wall, OR-reduced.
REQ-022 SHALL deliver companion block clkdiv (ports clk, rst, clkdiv[31:0]): free-running counter, synchronous reset to 0, +1 per clk, wraps 0xFFFFFFFF to 0.

Verification
REQ-023 rst=1 for 2 cycles with any inputs -> result=0; clkdiv=0.
REQ-024 (200,146) state 00 -> result=1 one cycle later; (200,16) state 00 -> 0; (200,17) state 00 -> 1.
REQ-025 macro defined: (263,220) state 11 -> 1; (264,220) state 11 -> 0 (touches W0 at x=280).
REQ-026 (0,0) state 10 -> 0 (no wrap); (608,100) state 11 -> 0; (607,100) state 11 -> 1.
REQ-027 macro undefined: (264,220) state 11 -> 1.
REQ-028 clkdiv: 5 clocks after reset release -> 5; preload/run to 0xFFFFFFFF, next clock -> 0.

Source files
------------

// File: rtl/collision_pkg.sv
// collision_pkg -- shared definitions for the sprite collision checker.
//   dir_t      : move direction encoding carried on check_collision.state
//   coord_t    : signed candidate coordinate, wide enough that a move of
//                PacX=0 left or PacY=0 up yields a negative value and not a
//                wrapped one
//   SPRITE_*   : default sprite size in pixels
//   ARENA_*    : default inclusive legal range of the sprite top-left corner
//   WALLS      : inner wall rectangles, inclusive pixel bounds
package collision_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam int CW = 12;
  typedef logic signed [CW-1:0] coord_t;

  localparam int SPRITE_W_DEF   = 16;
  localparam int SPRITE_H_DEF   = 16;
  localparam int ARENA_XMIN_DEF = 16;
  localparam int ARENA_XMAX_DEF = 608;
  localparam int ARENA_YMIN_DEF = 16;
  localparam int ARENA_YMAX_DEF = 448;

  typedef struct packed {
    int x0;
    int x1;
    int y0;
    int y1;
  } rect_t;

  localparam int NUM_WALLS = 8;

  localparam rect_t WALLS [NUM_WALLS] = '{
    '{x0: 280, x1: 359, y0: 200, y1: 279},
    '{x0:  64, x1: 127, y0:  64, y1:  95},
    '{x0: 512, x1: 575, y0:  64, y1:  95},
    '{x0:  64, x1: 127, y0: 384, y1: 415},
    '{x0: 512, x1: 575, y0: 384, y1: 415},
    '{x0: 160, x1: 175, y0: 200, y1: 279},
    '{x0: 464, x1: 479, y0: 200, y1: 279},
    '{x0: 280, x1: 359, y0:  64, y1:  79}
  };

endpackage

// File: rtl/clkdiv.sv
// clkdiv -- free-running 32-bit cycle counter.
//   clk    : system clock
//   rst    : synchronous active-high reset, clears the count
//   clkdiv : current count, +1 per clock, wraps 0xFFFFFFFF -> 0
module clkdiv (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] clkdiv
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + 32'd1;
  end

  assign clkdiv = count;

endmodule

// File: rtl/wall_hit.sv
// wall_hit -- overlap test of the sprite box at a candidate position against
// one wall rectangle (all bounds inclusive).
//   cx, cy : candidate top-left corner, signed
//   hit    : 1 when the box overlaps the rectangle on both axes
module wall_hit
  import collision_pkg::*;
#(
  parameter int X0       = 0,
  parameter int X1       = 0,
  parameter int Y0       = 0,
  parameter int Y1       = 0,
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  logic signed [CW-1:0] cx,
  input  logic signed [CW-1:0] cy,
  output logic                 hit
);

  int lx;
  int ly;

  always_comb begin
    lx  = int'(cx);
    ly  = int'(cy);
    hit = (lx <= X1) && (lx + SPRITE_W - 1 >= X0) &&
          (ly <= Y1) && (ly + SPRITE_H - 1 >= Y0);
  end

endmodule

// File: rtl/check_collision.sv
// check_collision -- decides whether a one-pixel sprite move is free.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset, forces result to 0
//   PacX   : sprite top-left X (10 bit, unsigned)
//   PacY   : sprite top-left Y (9 bit, unsigned)
//   state  : intended direction (00 up, 01 down, 10 left, 11 right)
//   result : registered, 1 = move free, 0 = blocked; one cycle latency
// Build option: define CHECK_COLLISION_INNER_WALLS_EN to also test the inner
// walls; otherwise only the arena bounds block a move.
module check_collision
  import collision_pkg::*;
#(
  parameter int SPRITE_W   = SPRITE_W_DEF,
  parameter int SPRITE_H   = SPRITE_H_DEF,
  parameter int ARENA_XMIN = ARENA_XMIN_DEF,
  parameter int ARENA_XMAX = ARENA_XMAX_DEF,
  parameter int ARENA_YMIN = ARENA_YMIN_DEF,
  parameter int ARENA_YMAX = ARENA_YMAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] PacX,
  input  logic [8:0] PacY,
  input  logic [1:0] state,
  output logic       result
);

  dir_t   dir;
  coord_t cx;
  coord_t cy;
  logic   oob;
  logic   wall_any;
  logic   free;

  // Only the candidate position is evaluated; the current position is never
  // tested, so a sprite already touching a wall can still move away.
  always_comb begin
    dir = dir_t'(state);
    cx  = coord_t'({2'b00, PacX});
    cy  = coord_t'({3'b000, PacY});
    unique case (dir)
      DIR_UP:    cy = cy - coord_t'(1);
      DIR_DOWN:  cy = cy + coord_t'(1);
      DIR_LEFT:  cx = cx - coord_t'(1);
      DIR_RIGHT: cx = cx + coord_t'(1);
    endcase
    oob  = (int'(cx) < ARENA_XMIN) || (int'(cx) > ARENA_XMAX) ||
           (int'(cy) < ARENA_YMIN) || (int'(cy) > ARENA_YMAX);
    free = !(oob || wall_any);
  end

`ifdef CHECK_COLLISION_INNER_WALLS_EN
  logic [NUM_WALLS-1:0] hits;

  for (genvar i = 0; i < NUM_WALLS; i++) begin : g_wall
    wall_hit #(
      .X0       (WALLS[i].x0),
      .X1       (WALLS[i].x1),
      .Y0       (WALLS[i].y0),
      .Y1       (WALLS[i].y1),
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
    ) u_wall (
      .cx  (cx),
      .cy  (cy),
      .hit (hits[i])
    );
  end

  assign wall_any = |hits;
`else
  // Sprite size only matters for the wall test.
  logic unused_sprite;
  assign unused_sprite = ^{SPRITE_W, SPRITE_H};
  assign wall_any      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) result <= 1'b0;
    else     result <= free;
  end

endmodule

// File: tb/tb_check_collision.sv
module tb_check_collision;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  PacX;
  logic [8:0]  PacY;
  logic [1:0]  state;
  logic        result;
  logic [31:0] div;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  check_collision #(
    .SPRITE_W   (16),
    .SPRITE_H   (16),
    .ARENA_XMIN (16),
    .ARENA_XMAX (608),
    .ARENA_YMIN (16),
    .ARENA_YMAX (448)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PacX   (PacX),
    .PacY   (PacY),
    .state  (state),
    .result (result)
  );

  clkdiv u_div (
    .clk    (clk),
    .rst    (rst),
    .clkdiv (div)
  );

  // Wall table written out independently from the requirements.
  int wx0 [8] = '{280,  64, 512,  64, 512, 160, 464, 280};
  int wx1 [8] = '{359, 127, 575, 127, 575, 175, 479, 359};
  int wy0 [8] = '{200,  64,  64, 384, 384, 200, 200,  64};
  int wy1 [8] = '{279,  95,  95, 415, 415, 279, 279,  79};

  // Reference: move one pixel, reject if the corner leaves the arena or the
  // 16x16 box shares any pixel with a wall (interval intersection non-empty).
  function automatic bit model_free(input int x, input int y, input int st);
    int nx, ny, lo, hi, lo2, hi2;
    nx = x;
    ny = y;
    case (st)
      0:       ny = y - 1;
      1:       ny = y + 1;
      2:       nx = x - 1;
      default: nx = x + 1;
    endcase
    if (nx < 16 || nx > 608 || ny < 16 || ny > 448) return 1'b0;
`ifdef CHECK_COLLISION_INNER_WALLS_EN
    for (int i = 0; i < 8; i++) begin
      lo  = (nx > wx0[i]) ? nx : wx0[i];
      hi  = (nx + 15 < wx1[i]) ? nx + 15 : wx1[i];
      lo2 = (ny > wy0[i]) ? ny : wy0[i];
      hi2 = (ny + 15 < wy1[i]) ? ny + 15 : wy1[i];
      if (lo <= hi && lo2 <= hi2) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  task automatic drive(input int x, input int y, input int st);
    PacX  = 10'(x);
    PacY  = 9'(y);
    state = 2'(st);
  endtask

  // Mix of full-range positions and positions hugging wall/arena edges.
  task automatic rand_vec(output int x, output int y, output int st);
    int w;
    st = int'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 511));
      end
      1: begin
        x = int'($urandom_range(0, 640));
        y = int'($urandom_range(0, 470));
      end
      2: begin
        w = int'($urandom_range(0, 7));
        x = ($urandom_range(0, 1) != 0) ? wx0[w] - 17 + int'($urandom_range(0, 3))
                                        : wx1[w] - 1 + int'($urandom_range(0, 3));
        y = wy0[w] - 8 + int'($urandom_range(0, 100));
      end
      default: begin
        w = int'($urandom_range(0, 7));
        y = ($urandom_range(0, 1) != 0) ? wy0[w] - 17 + int'($urandom_range(0, 3))
                                        : wy1[w] - 1 + int'($urandom_range(0, 3));
        x = wx0[w] - 8 + int'($urandom_range(0, 100));
      end
    endcase
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    if (x > 1023) x = 1023;
    if (y > 511) y = 511;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(200, 146, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (result !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_result: got %b expected 0", result);
    end
    compared++;
    if (div !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_clkdiv: got %0d expected 0", div);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int tx [$] = '{200, 200, 200,   0, 608, 607, 264, 263};
    int ty [$] = '{146,  16,  17,   0, 100, 100, 220, 220};
    int ts [$] = '{  0,   0,   0,   2,   3,   3,   3,   3};
`ifdef CHECK_COLLISION_INNER_WALLS_EN
    bit te [$] = '{  1,   0,   1,   0,   0,   1,   0,   1};
`else
    bit te [$] = '{  1,   0,   1,   0,   0,   1,   1,   1};
`endif
    for (int i = 0; i < tx.size(); i++) begin
      @(negedge clk);
      drive(tx[i], ty[i], ts[i]);
      @(negedge clk);
      compared++;
      if (result !== te[i]) begin
        mismatched++;
        $display("FAIL directed(%0d,%0d,st%0d): got %b expected %b",
                 tx[i], ty[i], ts[i], result, te[i]);
      end
    end
  endtask

  task automatic test_random();
    int x, y, st;
    bit e;
    for (int i = 0; i < 400; i++) begin
      rand_vec(x, y, st);
      @(negedge clk);
      drive(x, y, st);
      e = model_free(x, y, st);
      @(negedge clk);
      compared++;
      if (result !== e) begin
        mismatched++;
        $display("FAIL random(%0d,%0d,st%0d): got %b expected %b", x, y, st, result, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int x, y, st;
    bit e_prev;
    rand_vec(x, y, st);
    @(negedge clk);
    drive(x, y, st);
    e_prev = model_free(x, y, st);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      compared++;
      if (result !== e_prev) begin
        mismatched++;
        $display("FAIL back_to_back #%0d: got %b expected %b", i, result, e_prev);
      end
      rand_vec(x, y, st);
      drive(x, y, st);
      e_prev = model_free(x, y, st);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(200, 146, 0);
    @(negedge clk);
    compared++;
    if (result !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_pre_reset: got %b expected 1", result);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (result !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_reset cycle %0d: got %b expected 0", i, result);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (result !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_resume: got %b expected 1", result);
    end
  endtask

  task automatic test_clkdiv();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++;
    if (div !== 32'd5) begin
      mismatched++;
      $display("FAIL clkdiv_count5: got %0d expected 5", div);
    end
    force u_div.count = 32'hFFFF_FFFF;
    #1;
    release u_div.count;
    #1;
    compared++;
    if (div !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("FAIL clkdiv_preload: got %h expected ffffffff", div);
    end
    @(negedge clk);
    compared++;
    if (div !== 32'd0) begin
      mismatched++;
      $display("FAIL clkdiv_wrap: got %h expected 00000000", div);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
